// File: rtl/osd_spi_master.sv
// SPI transmitter for the OSD command port: one command byte, then an optional
// 256-byte line payload, MSB first, receiver sampling on the SCK rising edge.
module osd_spi_master #(
  parameter int CLK_DIV = 2,
  parameter int GAP     = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [2:0] req_line,
  input  logic       dat_valid,
  output logic       dat_ready,
  input  logic [7:0] dat_byte,
  output logic       busy,
  output logic       SPI_SCK,
  output logic       SPI_SS3,
  output logic       SPI_DO,
  output logic [2:0] dbg_state
);

  // Handshakes: a request transfers on a clk_sys edge where req_valid && req_ready;
  // a payload byte transfers on an edge where dat_valid is high while the shifter
  // needs a byte, and dat_ready pulses for one cycle right after that edge.

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_GAP      = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LD = 8'(CLK_DIV - 1);
  // Two cycles of the high time are covered by the tail edge and the IDLE cycle.
  localparam logic [7:0] GAP_LD = 8'((GAP >= 2) ? (GAP - 2) : 0);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [8:0]  pay_q, pay_d;
  logic [7:0]  sh_q, sh_d;
  logic        tail_q, tail_d;
  logic [7:0]  gap_q, gap_d;
  logic        sck_q, sck_d;
  logic        ss3_q, ss3_d;
  logic        do_q, do_d;
  logic        dat_ready_q, dat_ready_d;
  logic        busy_q, busy_d;
  logic [7:0]  cmd;
  logic        take;

  always_comb begin
    cmd = 8'h40;
    case (req_op)
      2'd0:    cmd = 8'h40;
      2'd1:    cmd = 8'h41;
      default: cmd = {5'b00100, req_line};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    pay_d       = pay_q;
    sh_d        = sh_q;
    tail_d      = tail_q;
    gap_d       = gap_q;
    sck_d       = sck_q;
    ss3_d       = ss3_q;
    do_d        = do_q;
    dat_ready_d = 1'b0;
    busy_d      = busy_q;
    take        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_op != 2'd3) begin
          sh_d    = cmd;
          do_d    = cmd[7];
          ss3_d   = 1'b0;
          bit_d   = 3'd7;
          div_d   = DIV_LD;
          pay_d   = (req_op == 2'd2) ? 9'd256 : 9'd0;
          tail_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT_LO;
        end
      end
      ST_LOAD: begin
        if (dat_valid) take = 1'b1;
      end
      ST_SHIFT_LO: begin
        if (div_q == 8'd0) begin
          if (tail_q) begin
            ss3_d = 1'b1;
            gap_d = GAP_LD;
            if (GAP <= 1) begin
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_GAP;
            end
          end else begin
            sck_d   = 1'b1;
            div_d   = DIV_LD;
            state_d = ST_SHIFT_HI;
          end
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      ST_SHIFT_HI: begin
        if (div_q == 8'd0) begin
          sck_d = 1'b0;
          div_d = DIV_LD;
          if (bit_q != 3'd0) begin
            sh_d    = {sh_q[6:0], 1'b0};
            do_d    = sh_q[6];
            bit_d   = bit_q - 3'd1;
            state_d = ST_SHIFT_LO;
          end else if (pay_q != 9'd0) begin
            if (dat_valid) take = 1'b1;
            else           state_d = ST_LOAD;
          end else begin
            tail_d  = 1'b1;
            state_d = ST_SHIFT_LO;
          end
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      ST_GAP: begin
        if (gap_q == 8'd0) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Payload load is shared by the no-stall path and the LOAD wait state.
    if (take) begin
      sh_d        = dat_byte;
      do_d        = dat_byte[7];
      bit_d       = 3'd7;
      pay_d       = pay_q - 9'd1;
      div_d       = DIV_LD;
      dat_ready_d = 1'b1;
      state_d     = ST_SHIFT_LO;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      div_q       <= 8'd0;
      bit_q       <= 3'd0;
      pay_q       <= 9'd0;
      sh_q        <= 8'd0;
      tail_q      <= 1'b0;
      gap_q       <= 8'd0;
      sck_q       <= 1'b0;
      ss3_q       <= 1'b1;
      do_q        <= 1'b0;
      dat_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      pay_q       <= pay_d;
      sh_q        <= sh_d;
      tail_q      <= tail_d;
      gap_q       <= gap_d;
      sck_q       <= sck_d;
      ss3_q       <= ss3_d;
      do_q        <= do_d;
      dat_ready_q <= dat_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign dat_ready = dat_ready_q;
  assign busy      = busy_q;
  assign SPI_SCK   = sck_q;
  assign SPI_SS3   = ss3_q;
  assign SPI_DO    = do_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_osd_spi_master.sv
// Directed bench for osd_spi_master: OSD receiver model on SCK rises, SS3/SCK
// timing monitor, and per-scenario tasks with hand-computed expectations.
module tb_osd_spi_master;

  localparam int CLK_DIV = 2;
  localparam int GAP     = 4;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'd0;
  logic [2:0] req_line = 3'd0;
  logic       dat_valid = 1'b0;
  logic       dat_ready;
  logic [7:0] dat_byte = 8'd0;
  logic       busy;
  logic       SPI_SCK;
  logic       SPI_SS3;
  logic       SPI_DO;
  logic [2:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;

  osd_spi_master #(.CLK_DIV(CLK_DIV), .GAP(GAP)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_line  (req_line),
    .dat_valid (dat_valid),
    .dat_ready (dat_ready),
    .dat_byte  (dat_byte),
    .busy      (busy),
    .SPI_SCK   (SPI_SCK),
    .SPI_SS3   (SPI_SS3),
    .SPI_DO    (SPI_DO),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  // OSD receiver model
  logic [7:0] rx_sr = 8'd0;
  int         rx_bits = 0;
  int         rx_idx = 0;
  int         rx_rises = 0;
  logic [7:0] rx_cmd = 8'd0;
  logic [2:0] rx_line = 3'd0;
  logic       osd_enable = 1'b0;
  logic [7:0] rx_mem [0:2047];

  always @(posedge SPI_SCK) begin
    if (SPI_SS3 === 1'b0) begin
      rx_sr = {rx_sr[6:0], SPI_DO};
      rx_bits++;
      rx_rises++;
      if (rx_bits == 8) begin
        rx_bits = 0;
        if (rx_idx == 0) begin
          rx_cmd = rx_sr;
          if (rx_sr == 8'h41)               osd_enable = 1'b1;
          else if (rx_sr == 8'h40)          osd_enable = 1'b0;
          else if (rx_sr[7:3] == 5'b00100)  rx_line = rx_sr[2:0];
        end else if (rx_cmd[7:3] == 5'b00100 && rx_idx <= 256) begin
          rx_mem[{rx_line, 8'(rx_idx - 1)}] = rx_sr;
        end
        rx_idx++;
      end
    end
  end

  always @(posedge SPI_SS3) begin
    rx_bits = 0;
    rx_idx  = 0;
  end

  // SS3 / SCK / dat_ready timing monitor, sampled on the falling clock edge
  int   low_cnt = 0, high_cnt = 0, last_low = 0, last_high = 0;
  int   lo_run = 0, max_lo = 0, dr_cnt = 0;
  logic prev_ss3 = 1'b1;

  always @(negedge clk_sys) begin
    if (SPI_SS3 === 1'b0) begin
      if (prev_ss3) last_high = high_cnt;
      high_cnt = 0;
      low_cnt++;
      if (SPI_SCK === 1'b0) begin
        lo_run++;
        if (lo_run > max_lo) max_lo = lo_run;
      end else begin
        lo_run = 0;
      end
    end else begin
      if (!prev_ss3) last_low = low_cnt;
      low_cnt = 0;
      high_cnt++;
      lo_run = 0;
    end
    if (dat_ready === 1'b1) dr_cnt++;
    prev_ss3 = SPI_SS3;
  end

  // driver tasks
  logic abort = 1'b0;

  task automatic clr_mon();
    #1;
    dr_cnt   = 0;
    rx_rises = 0;
    max_lo   = 0;
  endtask

  task automatic do_req(input logic [1:0] op, input logic [2:0] line, output int waited);
    waited = 0;
    @(negedge clk_sys);
    req_op    = op;
    req_line  = line;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && waited < 20000) begin
      @(negedge clk_sys);
      waited++;
    end
    if (req_ready !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL req_accept: req_ready=%b after %0d cycles, required 1", req_ready, waited);
    end
    @(negedge clk_sys);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || SPI_SS3 !== 1'b1) && n < 20000) begin
      @(negedge clk_sys);
      n++;
    end
    n_vec++;
    if (busy !== 1'b0 || SPI_SS3 !== 1'b1) begin
      n_err++;
      $display("FAIL idle_timeout: busy=%b ss3=%b, required busy=0 ss3=1", busy, SPI_SS3);
    end
  endtask

  // Supplies byte i ^ key; optionally withholds byte stall_idx so that it is
  // sampled 10 cycles later than the shifter first asks for it.
  task automatic feed(input logic [7:0] key, input int stall_idx);
    for (int i = 0; i < 256; i++) begin
      int n = 0;
      if (abort) break;
      dat_byte  = 8'(i) ^ key;
      dat_valid = 1'b1;
      do begin
        @(negedge clk_sys);
        n++;
      end while (dat_ready !== 1'b1 && n < 500 && !abort);
      if (abort) break;
      if (dat_ready !== 1'b1) begin
        n_vec++;
        n_err++;
        $display("FAIL feed_timeout: byte %0d dat_ready=%b, required 1", i, dat_ready);
        break;
      end
      if (i + 1 == stall_idx) begin
        // next byte is needed 32 cycles after this pulse; hold off 41+1 -> 10-cycle stall
        dat_valid = 1'b0;
        repeat (41) @(negedge clk_sys);
      end
    end
    dat_valid = 1'b0;
  endtask

  function automatic int line_errs(input logic [2:0] ln, input logic [7:0] key,
                                   input int lo, input int hi);
    int e = 0;
    for (int k = lo; k <= hi; k++)
      if (rx_mem[{ln, 8'(k)}] !== (8'(k) ^ key)) e++;
    return e;
  endfunction

  // scenario tasks
  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_vec++; if (SPI_SS3 !== 1'b1)   begin n_err++; $display("FAIL rst_ss3: got %b, required 1", SPI_SS3); end
    n_vec++; if (SPI_SCK !== 1'b0)   begin n_err++; $display("FAIL rst_sck: got %b, required 0", SPI_SCK); end
    n_vec++; if (SPI_DO !== 1'b0)    begin n_err++; $display("FAIL rst_do: got %b, required 0", SPI_DO); end
    n_vec++; if (dat_ready !== 1'b0) begin n_err++; $display("FAIL rst_dat_ready: got %b, required 0", dat_ready); end
    n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy); end
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %b, required 1", req_ready); end
    n_vec++; if (dbg_state !== 3'd0) begin n_err++; $display("FAIL rst_state: got %0d, required 0", dbg_state); end
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_enable_disable();
    int w;
    clr_mon();
    do_req(2'd1, 3'd0, w);
    n_vec++; if (SPI_SS3 !== 1'b0)   begin n_err++; $display("FAIL en_ss3_fall: got %b, required 0", SPI_SS3); end
    n_vec++; if (busy !== 1'b1)      begin n_err++; $display("FAIL en_busy: got %b, required 1", busy); end
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL en_req_ready: got %b, required 0", req_ready); end
    @(negedge clk_sys);
    n_vec++; if (SPI_SCK !== 1'b0)   begin n_err++; $display("FAIL en_sck_early: got %b, required 0", SPI_SCK); end
    @(negedge clk_sys);
    n_vec++; if (SPI_SCK !== 1'b1)   begin n_err++; $display("FAIL en_sck_first_rise: got %b, required 1", SPI_SCK); end
    wait_idle();
    n_vec++; if (last_low !== 34)    begin n_err++; $display("FAIL en_ss3_low: got %0d, required 34", last_low); end
    n_vec++; if (rx_rises !== 8)     begin n_err++; $display("FAIL en_rises: got %0d, required 8", rx_rises); end
    n_vec++; if (rx_cmd !== 8'h41)   begin n_err++; $display("FAIL en_cmd: got %h, required 41", rx_cmd); end
    n_vec++; if (osd_enable !== 1'b1) begin n_err++; $display("FAIL en_osd_enable: got %b, required 1", osd_enable); end
    clr_mon();
    do_req(2'd0, 3'd0, w);
    wait_idle();
    n_vec++; if (rx_cmd !== 8'h40)   begin n_err++; $display("FAIL dis_cmd: got %h, required 40", rx_cmd); end
    n_vec++; if (osd_enable !== 1'b0) begin n_err++; $display("FAIL dis_osd_enable: got %b, required 0", osd_enable); end
    n_vec++; if (dr_cnt !== 0)       begin n_err++; $display("FAIL dis_dat_ready: got %0d pulses, required 0", dr_cnt); end
  endtask

  task automatic test_write_line();
    int w;
    clr_mon();
    fork
      feed(8'h00, -1);
      do_req(2'd2, 3'd5, w);
    join
    wait_idle();
    n_vec++; if (rx_cmd !== 8'h25)   begin n_err++; $display("FAIL wr_cmd: got %h, required 25", rx_cmd); end
    n_vec++; if (dr_cnt !== 256)     begin n_err++; $display("FAIL wr_dat_ready: got %0d, required 256", dr_cnt); end
    n_vec++; if (line_errs(3'd5, 8'h00, 0, 255) !== 0)
      begin n_err++; $display("FAIL wr_buffer: got %0d bad bytes, required 0", line_errs(3'd5, 8'h00, 0, 255)); end
    n_vec++; if (last_low !== 8226)  begin n_err++; $display("FAIL wr_ss3_low: got %0d, required 8226", last_low); end
    n_vec++; if (rx_rises !== 2056)  begin n_err++; $display("FAIL wr_rises: got %0d, required 2056", rx_rises); end
    n_vec++; if (max_lo !== 2)       begin n_err++; $display("FAIL wr_max_sck_low: got %0d, required 2", max_lo); end
  endtask

  task automatic test_stall();
    int w;
    clr_mon();
    fork
      feed(8'hA5, 3);
      do_req(2'd2, 3'd1, w);
    join
    wait_idle();
    n_vec++; if (last_low !== 8236)  begin n_err++; $display("FAIL st_ss3_low: got %0d, required 8236", last_low); end
    n_vec++; if (max_lo !== 12)      begin n_err++; $display("FAIL st_sck_low_run: got %0d, required 12", max_lo); end
    n_vec++; if (rx_rises !== 2056)  begin n_err++; $display("FAIL st_rises: got %0d, required 2056", rx_rises); end
    n_vec++; if (rx_mem[{3'd1, 8'd3}] !== 8'hA6)
      begin n_err++; $display("FAIL st_byte3: got %h, required a6", rx_mem[{3'd1, 8'd3}]); end
    n_vec++; if (line_errs(3'd1, 8'hA5, 0, 255) !== 0)
      begin n_err++; $display("FAIL st_buffer: got %0d bad bytes, required 0", line_errs(3'd1, 8'hA5, 0, 255)); end
  endtask

  task automatic test_back_to_back();
    int w1, w2;
    clr_mon();
    do_req(2'd1, 3'd0, w1);
    do_req(2'd0, 3'd0, w2);
    wait_idle();
    n_vec++; if (last_high !== GAP)  begin n_err++; $display("FAIL b2b_gap: got %0d, required %0d", last_high, GAP); end
    // second request waits from accept+1.5 until IDLE at accept+37
    n_vec++; if (w2 !== 36)          begin n_err++; $display("FAIL b2b_ready_wait: got %0d, required 36", w2); end
    n_vec++; if (rx_cmd !== 8'h40)   begin n_err++; $display("FAIL b2b_cmd: got %h, required 40", rx_cmd); end
    n_vec++; if (rx_rises !== 16)    begin n_err++; $display("FAIL b2b_rises: got %0d, required 16", rx_rises); end
  endtask

  task automatic test_op3();
    int   w;
    int   bad = 0;
    logic do_before;
    repeat (2) @(negedge clk_sys);
    do_before = SPI_DO;
    do_req(2'd3, 3'd0, w);
    for (int i = 0; i < 6; i++) begin
      if (req_ready !== 1'b1 || busy !== 1'b0 || SPI_SS3 !== 1'b1 ||
          SPI_SCK !== 1'b0 || SPI_DO !== do_before) bad++;
      @(negedge clk_sys);
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL op3_idle: got %0d disturbed cycles, required 0", bad); end
    n_vec++; if (dbg_state !== 3'd0) begin n_err++; $display("FAIL op3_state: got %0d, required 0", dbg_state); end
  endtask

  task automatic test_reset_mid();
    int w;
    int n = 0;
    clr_mon();
    fork
      feed(8'h5A, -1);
      begin
        do_req(2'd2, 3'd3, w);
        while (dr_cnt < 100 && n < 20000) begin
          @(negedge clk_sys);
          n++;
        end
        n_vec++; if (dr_cnt !== 100) begin n_err++; $display("FAIL rm_reach: got %0d pulses, required 100", dr_cnt); end
        #2;
        reset = 1'b1;
        abort = 1'b1;
        #1;
        n_vec++; if (SPI_SS3 !== 1'b1)   begin n_err++; $display("FAIL rm_ss3: got %b, required 1", SPI_SS3); end
        n_vec++; if (SPI_SCK !== 1'b0 || SPI_DO !== 1'b0 || dat_ready !== 1'b0)
          begin n_err++; $display("FAIL rm_spi: sck=%b do=%b dr=%b, required 0 0 0", SPI_SCK, SPI_DO, dat_ready); end
        n_vec++; if (busy !== 1'b0 || req_ready !== 1'b1)
          begin n_err++; $display("FAIL rm_ctrl: busy=%b ready=%b, required 0 1", busy, req_ready); end
      end
    join
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk_sys);
    clr_mon();
    fork
      feed(8'h3C, -1);
      do_req(2'd2, 3'd2, w);
    join
    wait_idle();
    n_vec++; if (line_errs(3'd2, 8'h3C, 0, 255) !== 0)
      begin n_err++; $display("FAIL rm_new_line: got %0d bad bytes, required 0", line_errs(3'd2, 8'h3C, 0, 255)); end
    n_vec++; if (last_low !== 8226)  begin n_err++; $display("FAIL rm_new_low: got %0d, required 8226", last_low); end
    n_vec++; if (dr_cnt !== 256)     begin n_err++; $display("FAIL rm_new_dat_ready: got %0d, required 256", dr_cnt); end
    n_vec++; if (line_errs(3'd3, 8'h5A, 0, 97) !== 0)
      begin n_err++; $display("FAIL rm_kept: got %0d bad bytes, required 0", line_errs(3'd3, 8'h5A, 0, 97)); end
    n_vec++; if (rx_mem[{3'd3, 8'd200}] !== 8'hEE)
      begin n_err++; $display("FAIL rm_untouched: got %h, required ee", rx_mem[{3'd3, 8'd200}]); end
  endtask

  initial begin
    for (int k = 0; k < 2048; k++) rx_mem[k] = 8'hEE;
    test_reset();
    test_enable_disable();
    test_write_line();
    test_stall();
    test_back_to_back();
    test_op3();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/osd_spi_master.md
# osd_spi_master

In-core SPI transmitter that drives the OSD command port (SPI_SCK / SPI_SS3 / data line) of the overlay module. It lets core logic, or a local menu engine, enable or disable the OSD and upload 256-byte lines without the IO controller. It sits in the clk_sys domain and replaces, or is muxed with, the external SPI lines that feed the OSD receiver. Framing: one command byte, then payload bytes. All bytes go MSB first; the receiver samples on the SCK rising edge.

## Interface

Parameters:
- CLK_DIV, default 2: SCK half-period in clk_sys cycles; legal range 1..255.
- GAP, default 4: clk_sys cycles SPI_SS3 is held high between transactions; minimum 1.

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  command request.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_op  in  2  0 = disable (0x40), 1 = enable (0x41), 2 = write line, 3 = reserved.
- req_line  in  3  OSD line for a write; command byte is 0x20 | req_line.
- dat_valid  in  1  payload byte available.
- dat_ready  out  1  one-cycle pulse when dat_byte is consumed.
- dat_byte  in  8  payload byte.
- busy  out  1  high from request accept until the GAP count ends.
- SPI_SCK  out  1  serial clock; idles low.
- SPI_SS3  out  1  OSD chip select, active low; idles high.
- SPI_DO  out  1  serial data to the OSD SPI_DI input.

## Operation

- States: IDLE, LOAD, SHIFT_LO, SHIFT_HI, GAP.
- IDLE:
  - On accept with op 0/1/2, latch the command byte and the payload count (0 for op 0/1, 256 for op 2). Go to LOAD with the command byte as the shift source.
  - op 3 is accepted and dropped: no SPI activity, no GAP, busy stays low.
- LOAD (start of each byte):
  - The command byte loads immediately.
  - For a payload byte, wait for dat_valid. When dat_valid is high, capture dat_byte, pulse dat_ready for exactly one cycle and load the byte.
  - While waiting: SPI_SS3 stays low, SPI_SCK stays low, SPI_DO holds its value.
  - On load, SPI_DO = bit 7; go to SHIFT_LO.
- SHIFT_LO: SCK low for CLK_DIV cycles, then SCK rises; go to SHIFT_HI.
- SHIFT_HI: SCK high for CLK_DIV cycles, then SCK falls. In the same cycle SPI_DO advances to the next bit.
  - After bit 0: if payload bytes remain, go to LOAD; otherwise go to SHIFT_LO for a final CLK_DIV-cycle low tail, then raise SPI_SS3 and go to GAP.
- GAP: SPI_SS3 high for GAP cycles, then go to IDLE.
- Counters:
  - bit counter: 3 bits, wraps.
  - payload counter: 9 bits, counts 256 down to 0; the transaction ends when it reaches 0 after a completed byte.
  - divider: 8 bits.
- SPI_DO only changes while SCK is low, or on the cycle SCK falls. It never changes on the cycle SCK rises.

## Timing

- All outputs are registered except req_ready, which is decoded from state.
- Reset values: SPI_SS3 = 1, SPI_SCK = 0, SPI_DO = 0, dat_ready = 0, busy = 0, req_ready = 1, state IDLE.
- Reset asserted mid-transaction: SPI_SS3 goes high asynchronously and the transaction is abandoned. The receiver discards any partial byte; bytes already written stay written.
- Accept to SPI_SS3 low: 1 cycle. SPI_DO = bit 7 in that same cycle.
- First SCK rising edge: CLK_DIV cycles after SS3 falls.
- SS3 low duration, no stalls: (16·N + 1)·CLK_DIV cycles, where N = number of bytes including the command byte.
  - N = 1 at CLK_DIV = 2: 34 cycles.
  - N = 257: 4113·CLK_DIV cycles.
- Earliest next accept: GAP cycles after SS3 rises.
- A payload stall adds exactly the stall cycles to the SCK-low phase before that byte's bit 7. No extra SCK edges occur during a stall.
- dat_ready never pulses for op 0/1.
- dat_ready pulses exactly 256 times per write.

## Test plan

- Enable, CLK_DIV = 2: SS3 low for 34 cycles, 8 SCK rises, bits sampled on the rises = 0x41. Checker OSD receiver model reports osd_enable = 1. A following disable yields 0x40 and osd_enable = 0.
- Write line 5 with bytes 0..255: command byte 0x25, 256 dat_ready pulses. Receiver buffer addresses 0x500..0x5FF hold 0x00..0xFF. SS3 low for 4113·2 cycles.
- Stall: dat_valid low for 10 cycles before payload byte 3. SCK stays low and SS3 stays low for those extra 10 cycles. Byte 3 is received intact, and total SS3 low time = nominal + 10.
- Back-to-back requests with GAP = 4: SS3 is high for exactly 4 cycles between transactions; req_ready is low until then.
- op 3 request: req_ready stays high, SS3/SCK/DO stay unchanged, busy stays 0.
- Reset asserted at payload byte 100: SS3 goes high in the same cycle and all outputs take their reset values. A fresh write line 2 afterwards completes correctly.
